// File: rtl/phy_rx_pkg.sv
// +----------------------------------------------------------------------------+
// | phy_rx_pkg: shared constants and FSM encoding for the serial RX aligner    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package phy_rx_pkg;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

    // 2'd3 is unused; the aligner treats it as SEARCH.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/phy_rx_comma_det.sv
// +----------------------------------------------------------------------------+
// | phy_rx_comma_det: serial shift register with per-cycle comma compare       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module phy_rx_comma_det
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COMMA = COMMA_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] win,
    output logic       is_comma
);

    // Only the seven youngest bits of the 8-bit shift register are ever
    // observable, since the window always combines them with the live bit.
    logic [6:0] r_sr;

    assign win      = {r_sr, data_in};
    assign is_comma = (win == COMMA);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_sr <= '0;
        end else begin
            r_sr <= win[6:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/phy_rx_serial_aligner.sv
// +----------------------------------------------------------------------------+
// | phy_rx_serial_aligner: comma-locked byte aligner for the PHY RX serial path|
// | Optional byte statistics counter enabled by PHY_RX_STATS_EN. Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module phy_rx_serial_aligner
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COMMA   = COMMA_DEFAULT,
    parameter int         BC_LOCK = 4,
    parameter int         CNT_W   = 16
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             byte_strobe,
    output logic             active
`ifdef PHY_RX_STATS_EN
    ,
    output logic [CNT_W-1:0] rx_byte_count
`endif
);

    localparam logic [3:0] LOCK_CNT = BC_LOCK[3:0];

    if (BC_LOCK < 1 || BC_LOCK > 15) begin : g_bad_bc_lock
        $error("BC_LOCK must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [7:0] w_win;
    logic       w_is_comma;

    phy_rx_comma_det #(
        .COMMA (COMMA)
    ) u_comma_det (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .win      (w_win),
        .is_comma (w_is_comma)
    );

    state_t     r_state, w_state_n;
    logic [2:0] r_bit_cnt, w_bit_cnt_n;
    logic [3:0] r_bc_cnt, w_bc_cnt_n;
    logic [7:0] r_data, w_data_n;
    logic       r_valid, w_valid_n;
    logic       r_strobe, w_strobe_n;
    logic       r_active, w_active_n;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state   <= SEARCH;
            r_bit_cnt <= '0;
            r_bc_cnt  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_strobe  <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_bc_cnt  <= w_bc_cnt_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_strobe  <= w_strobe_n;
            r_active  <= w_active_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_bit_cnt_n = r_bit_cnt;
        w_bc_cnt_n  = r_bc_cnt;
        w_data_n    = r_data;
        w_valid_n   = r_valid;
        w_strobe_n  = 1'b0;

        case (r_state)
            ALIGN: begin
                w_bit_cnt_n = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    if (w_is_comma) begin
                        w_bc_cnt_n = r_bc_cnt + 4'd1;
                        if (r_bc_cnt + 4'd1 == LOCK_CNT) begin
                            w_state_n = ACTIVE;
                        end
                    end else begin
                        w_bc_cnt_n = '0;
                        w_state_n  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                w_bit_cnt_n = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    w_data_n   = w_win;
                    w_valid_n  = ~w_is_comma;
                    w_strobe_n = 1'b1;
                end
            end
            default: begin
                // Any bit position may start a comma while hunting.
                if (w_is_comma) begin
                    w_bit_cnt_n = '0;
                    w_bc_cnt_n  = 4'd1;
                    w_state_n   = (LOCK_CNT == 4'd1) ? ACTIVE : ALIGN;
                end
            end
        endcase

        w_active_n = (w_state_n == ACTIVE);
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active      = r_active;

`ifdef PHY_RX_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_count_inc;
    logic [CNT_W-1:0] r_count;

    assign w_count_inc = (r_state == ACTIVE) && (r_bit_cnt == 3'd7) && !w_is_comma;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_count_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign rx_byte_count = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_phy_rx_serial_aligner.sv
// +----------------------------------------------------------------------------+
// | tb_phy_rx_serial_aligner: directed self-checking bench for the RX aligner  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_phy_rx_serial_aligner;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;
`ifdef PHY_RX_STATS_EN
    logic [3:0] rx_byte_count;
`endif

    always #5 clk_32f = ~clk_32f;

    phy_rx_serial_aligner #(
        .COMMA   (8'hBC),
        .BC_LOCK (4),
        .CNT_W   (4)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
`ifdef PHY_RX_STATS_EN
        ,
        .rx_byte_count (rx_byte_count)
`endif
    );

    typedef struct {
        logic [7:0] tx;
        logic [7:0] data;
        logic       valid;
        logic       strobe;
        logic       act;
    } vec_t;

    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    // Called at a negedge; drives bits hi..lo MSB first, returns at a negedge.
    task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            data_in = b[i];
            @(negedge clk_32f);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 7, 0);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic v,
                              input logic s, input logic a);
        check({tag, ".data_out"},    {24'd0, data_out}, {24'd0, d});
        check({tag, ".valid_out"},   {31'd0, valid_out}, {31'd0, v});
        check({tag, ".byte_strobe"}, {31'd0, byte_strobe}, {31'd0, s});
        check({tag, ".active"},      {31'd0, active}, {31'd0, a});
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        data_in = 1'b0;
        repeat (2) @(negedge clk_32f);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hBC, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'hEE, 8'hEE, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{8'hBC, 8'hBC, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{8'h77, 8'h77, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{8'hBC, 8'hBC, 1'b0, 1'b1, 1'b1};

        reset   = 1'b1;
        data_in = 1'b0;
        @(negedge clk_32f);
        do_reset();
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef PHY_RX_STATS_EN
        check("reset.rx_byte_count", {28'd0, rx_byte_count}, 32'd0);
`endif

        // Lock on 4 commas, then data and idle bytes
        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].tx);
            check_outs($sformatf("vec%0d", i), vecs[i].data, vecs[i].valid,
                       vecs[i].strobe, vecs[i].act);
        end

        // Strobe is a single-cycle pulse and outputs hold mid-byte
        send_bits(8'h5A, 7, 7);
        check_outs("hold", 8'hBC, 1'b0, 1'b0, 1'b1);
        send_bits(8'h5A, 6, 0);
        check_outs("after_hold", 8'h5A, 1'b1, 1'b1, 1'b1);

`ifdef PHY_RX_STATS_EN
        check("stats.four", {28'd0, rx_byte_count}, 32'd4);
        for (int i = 0; i < 10; i++) send_byte(8'h3C);
        send_byte(8'hBC);
        check("stats.no_bc", {28'd0, rx_byte_count}, 32'd14);
        for (int i = 0; i < 10; i++) send_byte(8'h3C);
        check("stats.saturate", {28'd0, rx_byte_count}, 32'd15);
`endif

        // Reset at bit 3 of a byte while active
        send_bits(8'hC3, 7, 5);
        reset = 1'b1;
        @(negedge clk_32f);
        check_outs("midbyte_reset", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef PHY_RX_STATS_EN
        check("midbyte_reset.rx_byte_count", {28'd0, rx_byte_count}, 32'd0);
`endif
        reset   = 1'b0;
        data_in = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check_outs("relock3", 8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'hBC);
        check_outs("relock4", 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h81);
        check_outs("relock_data", 8'h81, 1'b1, 1'b1, 1'b1);

        // Three junk bits ahead of the commas must not shift alignment
        do_reset();
        send_bits(8'h03, 2, 0);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        check_outs("junk_lock", 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5);
        check_outs("junk_data", 8'hA5, 1'b1, 1'b1, 1'b1);

        // A non-comma byte during ALIGN restarts the comma count
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h55);
        check_outs("align_break", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check_outs("align_3bc", 8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'hBC);
        check_outs("align_4bc", 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h12);
        check_outs("align_data", 8'h12, 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
